// File: rtl/trace_pkg.sv
// Shared constants, serializer state type and record word selection for the trace recorder.
package trace_pkg;

  localparam int TRACE_REC_W  = 96;
  localparam int TRACE_WORDS  = 3;
  localparam int TRACE_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    W0,
    W1,
    W2
  } ser_state_t;

  // Word 0 is the instruction (record MSBs), word 2 the write-back result (LSBs).
  function automatic logic [TRACE_WORD_W-1:0] rec_word(input logic [TRACE_REC_W-1:0] rec,
                                                       input logic [1:0]             idx);
    int base;
    base = (TRACE_WORDS - 1 - int'(idx)) * TRACE_WORD_W;
    return rec[base +: TRACE_WORD_W];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH x 96-bit record FIFO; pointers carry one extra bit so full and empty are distinct.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [TRACE_REC_W-1:0] push_data,
  input  logic                   pop,
  output logic [TRACE_REC_W-1:0] head_data,
  output logic [TRACE_REC_W-1:0] next_data,
  output logic                   full,
  output logic                   empty,
  output logic                   has_next
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;

  logic [TRACE_REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count;
  logic [AW-1:0]          rd_idx_next;
  logic                   do_push, do_pop;

  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign has_next    = (count > PTR_ONE);
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign rd_idx_next = rd_ptr_q[AW-1:0] + IDX_ONE;
  assign head_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign next_data   = mem_q[rd_idx_next];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/trace_recorder.sv
// Retired-instruction trace recorder: buffers 96-bit records and streams them as three 32-bit words.
// Optional build macro TRACE_NOP_FILTER_EN discards records whose instruction is all zero.
module trace_recorder
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_valid,
  input  logic [31:0]      cap_instr,
  input  logic [31:0]      cap_pc4,
  input  logic [31:0]      cap_result,
  input  logic             cap_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  input  logic             drop_clr,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  logic                   cap_fire;
  logic                   push, drop, pop;
  logic                   fifo_full, fifo_empty, fifo_has_next;
  logic [TRACE_REC_W-1:0] cap_rec, head_data, next_data;

  ser_state_t             state_q;
  logic                   out_valid_q, out_last_q;
  logic [31:0]            out_data_q;
  logic [CNT_W-1:0]       drop_count_q, drop_count_d;
  logic                   overflow_q, overflow_d;

`ifdef TRACE_NOP_FILTER_EN
  assign cap_fire = cap_valid & cap_en & (cap_instr != 32'h0000_0000);
`else
  assign cap_fire = cap_valid & cap_en;
`endif

  // Fullness is judged at the start of the cycle, so a same-cycle pop never rescues a push.
  assign cap_rec = {cap_instr, cap_pc4, cap_result};
  assign push    = cap_fire & ~fifo_full;
  assign drop    = cap_fire & fifo_full;
  assign pop     = (state_q == W2) & out_ready;

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(cap_rec),
    .pop      (pop),
    .head_data(head_data),
    .next_data(next_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .has_next (fifo_has_next)
  );

  always_comb begin
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (drop_clr) begin
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != {CNT_W{1'b1}}) drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Outputs are loaded on the edge that enters each state, so they hold steady during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= W0;
            out_valid_q <= 1'b1;
            out_data_q  <= rec_word(head_data, 2'd0);
            out_last_q  <= 1'b0;
          end
        end
        W0: begin
          if (out_ready) begin
            state_q    <= W1;
            out_data_q <= rec_word(head_data, 2'd1);
          end
        end
        W1: begin
          if (out_ready) begin
            state_q    <= W2;
            out_data_q <= rec_word(head_data, 2'd2);
            out_last_q <= 1'b1;
          end
        end
        W2: begin
          if (out_ready) begin
            out_last_q <= 1'b0;
            if (fifo_has_next) begin
              state_q    <= W0;
              out_data_q <= rec_word(next_data, 2'd0);
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_recorder.sv
// Self-checking bench for trace_recorder: queue-based reference model plus directed and random traffic.
module tb_trace_recorder;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cap_valid = 1'b0;
  logic [31:0]      cap_instr = '0;
  logic [31:0]      cap_pc4 = '0;
  logic [31:0]      cap_result = '0;
  logic             cap_en = 1'b0;
  logic             out_ready = 1'b0;
  logic             drop_clr = 1'b0;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_last;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  trace_recorder #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_valid (cap_valid),
    .cap_instr (cap_instr),
    .cap_pc4   (cap_pc4),
    .cap_result(cap_result),
    .cap_en    (cap_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_clr  (drop_clr),
    .drop_count(drop_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic en, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic [31:0] res,
                               input logic rdy, input logic clr);
    cap_valid  = v;
    cap_en     = en;
    cap_instr  = instr;
    cap_pc4    = pc4;
    cap_result = res;
    out_ready  = rdy;
    drop_clr   = clr;
  endtask

  task automatic applyIdle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  function automatic logic [31:0] expWord(input logic [95:0] r, input int k);
    if (k == 0) return r[95:64];
    if (k == 1) return r[63:32];
    return r[31:0];
  endfunction

  // Reference model: records waiting (head is the one being sent), word index of the head, sending flag.
  logic [95:0] mq[$];
  int          wi = 0;
  bit          active = 1'b0;
  int          drops = 0;
  bit          ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit fire;
    bit was_full;
    int pre_size;
    if (!rst_n) begin
      mq.delete();
      wi     = 0;
      active = 1'b0;
      drops  = 0;
      ovf    = 1'b0;
    end else begin
      fire = cap_valid && cap_en;
`ifdef TRACE_NOP_FILTER_EN
      fire = fire && (cap_instr != 32'h0);
`endif
      pre_size = mq.size();
      was_full = (pre_size == DEPTH);
      if (active && out_ready) begin
        if (wi < 2) begin
          wi++;
        end else begin
          void'(mq.pop_front());
          wi     = 0;
          active = (pre_size >= 2);
        end
      end else if (!active && pre_size > 0) begin
        active = 1'b1;
        wi     = 0;
      end
      if (fire && !was_full) mq.push_back({cap_instr, cap_pc4, cap_result});
      if (drop_clr) begin
        drops = 0;
        ovf   = 1'b0;
      end else if (fire && was_full) begin
        if (drops < CNT_MAX) drops++;
        ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] ed;
    ed = active ? expWord(mq[0], wi) : 32'h0;
    checkOutput("out_valid", 32'(out_valid), 32'(active));
    checkOutput("out_data", out_data, ed);
    checkOutput("out_last", 32'(out_last), 32'(active && wi == 2));
    checkOutput("drop_count", 32'(drop_count), 32'(drops));
    checkOutput("overflow", 32'(overflow), 32'(ovf));
  end

  initial begin : main
    int n;
    applyIdle(1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data", out_data, 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Single record, consumer always ready
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h2002_0005, 32'h4, 32'h5, 1'b1, 1'b0);
    @(negedge clk);
    applyIdle(1'b1);
    checkOutput("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("w0_valid", 32'(out_valid), 32'd1);
    checkOutput("w0_data", out_data, 32'h2002_0005);
    checkOutput("w0_last", 32'(out_last), 32'd0);
    @(negedge clk);
    checkOutput("w1_data", out_data, 32'h4);
    checkOutput("w1_last", 32'(out_last), 32'd0);
    @(negedge clk);
    checkOutput("w2_data", out_data, 32'h5);
    checkOutput("w2_last", 32'(out_last), 32'd1);
    @(negedge clk);
    checkOutput("after_valid", 32'(out_valid), 32'd0);
    checkOutput("after_data", out_data, 32'd0);

    // Stall for five cycles while the PC+4 word is presented
    applyStimulus(1'b1, 1'b1, 32'hA0A0_0001, 32'h4, 32'h5, 1'b1, 1'b0);
    @(negedge clk);
    applyIdle(1'b1);
    @(negedge clk);
    checkOutput("stall_w0_data", out_data, 32'hA0A0_0001);
    @(negedge clk);
    checkOutput("stall_w1_data", out_data, 32'h4);
    applyIdle(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_data", out_data, 32'h4);
      checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
    end
    applyIdle(1'b1);
    @(negedge clk);
    checkOutput("stall_resume_data", out_data, 32'h5);
    checkOutput("stall_resume_last", 32'(out_last), 32'd1);
    @(negedge clk);

    // Ten back-to-back pushes with the consumer blocked
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
      @(negedge clk);
    end
    applyIdle(1'b0);
    @(negedge clk);
    checkOutput("fill_drop_count", 32'(drop_count), 32'd2);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 32'hDEAD_0000 + 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
    end
    applyIdle(1'b0);
    @(negedge clk);
    checkOutput("sat_drop_count", 32'(drop_count), 32'(CNT_MAX));
    checkOutput("sat_overflow", 32'(overflow), 32'd1);

    // Clear colliding with a drop
    applyStimulus(1'b1, 1'b1, 32'hBEEF_0001, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    applyIdle(1'b0);
    @(negedge clk);
    checkOutput("clr_drop_count", 32'(drop_count), 32'd0);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);

    applyIdle(1'b1);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid && out_last) n++;
    end
    checkOutput("stored_records", 32'(n), 32'd8);

    // Reset asserted while the second word is on the bus
    applyStimulus(1'b1, 1'b1, 32'hC0DE_0001, 32'h8, 32'h9, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'hC0DE_0002, 32'hC, 32'hD, 1'b1, 1'b0);
    @(negedge clk);
    applyIdle(1'b1);
    @(negedge clk);
    checkOutput("pre_rst_w1_data", out_data, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_data", out_data, 32'd0);
    checkOutput("rst_mid_last", 32'(out_last), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no_resend_valid", 32'(out_valid), 32'd0);
    end

`ifdef TRACE_NOP_FILTER_EN
    n = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h4 * 32'(i), 32'(i), 1'b1, 1'b0);
      @(negedge clk);
      if (out_valid) n++;
    end
    applyIdle(1'b1);
    repeat (6) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checkOutput("nop_no_words", 32'(n), 32'd0);
    checkOutput("nop_drop_count", 32'(drop_count), 32'd0);
`endif

    // Randomized traffic, alternating fast and slow consumer phases
    for (int i = 0; i < 3000; i++) begin
      logic v, en, rdy, clr;
      logic [31:0] ins;
      v   = ($urandom_range(0, 99) < 60);
      en  = ($urandom_range(0, 99) < 90);
      rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 15);
      clr = ($urandom_range(0, 99) < 2);
      ins = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      applyStimulus(v, en, ins, $urandom, $urandom, rdy, clr);
      @(negedge clk);
    end
    applyIdle(1'b1);
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_recorder.md
TRACE_RECORDER -- requirements
Module: trace_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, record FIFO depth; a power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 8, width of the drop counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cap_valid, input, 1 bit: the processor presents a retired-instruction record this cycle.
REQ-006 SHALL have ports cap_instr, cap_pc4 and cap_result, inputs, 32 bits each: instruction, PC+4 and write-back result.
REQ-007 SHALL have port cap_en, input, 1 bit: capture enable; while it is 0, cap_valid is ignored.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-010 SHALL have port out_data, output, 32 bits: serialized trace word.
REQ-011 SHALL have port out_last, output, 1 bit: marks the third (final) word of a record.
REQ-012 SHALL have port drop_clr, input, 1 bit: synchronous clear of drop_count and overflow.
REQ-013 SHALL have port drop_count, output, CNT_W bits: count of dropped records.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set by any drop.

Function
REQ-015 SHALL push the 96-bit record {cap_instr, cap_pc4, cap_result} into the FIFO on a cycle where cap_valid=1, cap_en=1 and the FIFO was not full at the start of that cycle.
REQ-016 SHALL drop the record and increment drop_count when cap_valid=1, cap_en=1 and the FIFO is full; a pop in the same cycle does not rescue the push.
REQ-017 SHALL saturate drop_count at all-ones, without wrap.
REQ-018 SHALL give drop_clr priority over a same-cycle drop: drop_count becomes 0 and overflow becomes 0.
REQ-019 SHALL serialize with FSM states IDLE, W0, W1, W2, emitting cap_instr in W0, cap_pc4 in W1 and cap_result in W2.
REQ-020 SHALL transition IDLE->W0 when the FIFO is non-empty; W0->W1 and W1->W2 on out_valid & out_ready; W2->W0 on handshake if another record is present, else W2->IDLE.
REQ-021 SHALL hold out_valid=1 in W0, W1 and W2, and keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL assert out_last only in W2.
REQ-023 SHALL pop the FIFO entry only on the W2 handshake.
REQ-024 SHALL have a latency of exactly 2 cycles from a push into an empty FIFO while in IDLE to out_valid=1 (FIFO write edge, then FSM edge).
REQ-025 SHALL wrap FIFO pointers modulo DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-026 SHALL drive out_data=0 while out_valid=0.

Reset
REQ-027 SHALL, while rst_n=0: empty the FIFO, set the FSM to IDLE and drive out_valid=0, out_data=0, out_last=0, drop_count=0 and overflow=0.
REQ-028 SHALL discard a partially sent record when reset is asserted mid-transfer; it is not resent.

Configuration
REQ-029 SHALL, with TRACE_NOP_FILTER_EN defined, silently ignore records whose cap_instr==32'h0000_0000: no push, no drop count.
REQ-030 SHALL, without TRACE_NOP_FILTER_EN defined, treat all-zero instructions like any other record.

Structure
REQ-031 SHALL place in package trace_pkg: the TRACE_REC_W=96 and TRACE_WORDS=3 constants and the serializer state enum typedef.
REQ-032 SHALL implement the FIFO as sub-module trace_fifo (DEPTH x 96, with push, pop, full and empty).

Verification
REQ-033 SHALL cover: one record {32'h2002_0005, 32'h4, 32'h5} with out_ready=1 -> words 32'h2002_0005, 32'h4, 32'h5 on consecutive cycles, out_last on the third word only.
REQ-034 SHALL cover: out_ready=0 for 5 cycles during W1 -> out_data stays 32'h4 and out_valid stays 1, then the transfer resumes.
REQ-035 SHALL cover: 10 back-to-back pushes with out_ready=0 and DEPTH=8 -> 8 records stored, drop_count=2, overflow=1.
REQ-036 SHALL cover: drop_clr and a drop in the same cycle -> drop_count=0, overflow=0.
REQ-037 SHALL cover: rst_n low during W1 -> outputs 0 immediately; after release, out_valid stays 0 with no pushes.
REQ-038 SHALL cover: with TRACE_NOP_FILTER_EN, pushes with cap_instr=0 -> no output words and drop_count unchanged.
